// File: rtl/alu_issue_ctrl_pkg.sv
// rtl/alu_issue_ctrl_pkg.sv - shared encodings for the ALU issue controller
package alu_issue_ctrl_pkg;

    localparam int REG_AW = 5;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [2:0] F3_ADD     = 3'b000;
    localparam logic [6:0] F7_ADD     = 7'b0000000;
    localparam logic [6:0] F7_SUB     = 7'b0100000;

    typedef enum logic [1:0] {
        ST_R_TYPE  = 2'd0,
        ST_I_TYPE  = 2'd1,
        ST_EOF     = 2'd2,
        ST_INVALID = 2'd3
    } status_e;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_e;

endpackage

// File: rtl/alu_issue_ctrl_reg_file.sv
// rtl/alu_issue_ctrl_reg_file.sv - 2R1W register file with hardwired-zero x0
module alu_issue_ctrl_reg_file
    import alu_issue_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [REG_AW-1:0]     i_raddr_a,
    output logic [DATA_WIDTH-1:0] o_rdata_a,
    input  logic [REG_AW-1:0]     i_raddr_b,
    output logic [DATA_WIDTH-1:0] o_rdata_b,
    input  logic                  i_we,
    input  logic [REG_AW-1:0]     i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata
);

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (i_we && (i_waddr != '0)) begin
            regs_q[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a = (i_raddr_a == '0) ? '0 : regs_q[i_raddr_a];
    assign o_rdata_b = (i_raddr_b == '0) ? '0 : regs_q[i_raddr_b];

endmodule

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - fetch/decode/issue/writeback controller in front of the integer ALU
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_REGS   = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    output logic [ADDR_WIDTH-1:0] o_imem_addr,
    input  logic [31:0]           i_imem_rdata,
    output logic [2:0]            o_alu_op,
    output logic [DATA_WIDTH-1:0] o_alu_a,
    output logic [DATA_WIDTH-1:0] o_alu_b,
    input  logic [DATA_WIDTH-1:0] i_alu_data,
    input  logic                  i_alu_overflow,
    output logic [1:0]            o_status,
    output logic                  o_status_valid,
    output logic                  o_halt
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, imem_addr_q;
    logic [REG_AW-1:0]     rd_q;
    status_e               kind_q, status_q;
    logic [2:0]            alu_op_q;
    logic [DATA_WIDTH-1:0] alu_a_q, alu_b_q, res_q;
    logic                  ovf_q;

    logic [6:0]            opcode, funct7;
    logic [2:0]            funct3;
    logic [REG_AW-1:0]     rs1, rs2;
    logic [DATA_WIDTH-1:0] rf_a, rf_b, imm_ext;
    status_e               dec_kind;
    logic [2:0]            dec_op;
    logic                  dec_imm;
    logic                  wb_ok, rf_we;
    logic [ADDR_WIDTH-1:0] pc_next;

    assign opcode  = i_imem_rdata[6:0];
    assign funct3  = i_imem_rdata[14:12];
    assign rs1     = i_imem_rdata[19:15];
    assign rs2     = i_imem_rdata[24:20];
    assign funct7  = i_imem_rdata[31:25];
    assign imm_ext = {{(DATA_WIDTH-12){i_imem_rdata[31]}}, i_imem_rdata[31:20]};

    always_comb begin
        dec_kind = ST_INVALID;
        dec_op   = ALU_ADD;
        dec_imm  = 1'b0;
        if (opcode == OPC_OP && funct3 == F3_ADD && funct7 == F7_ADD) begin
            dec_kind = ST_R_TYPE;
        end else if (opcode == OPC_OP && funct3 == F3_ADD && funct7 == F7_SUB) begin
            dec_kind = ST_R_TYPE;
            dec_op   = ALU_SUB;
        end else if (opcode == OPC_OP_IMM && funct3 == F3_ADD) begin
            dec_kind = ST_I_TYPE;
            dec_imm  = 1'b1;
        end else if (opcode == OPC_SYSTEM) begin
            dec_kind = ST_EOF;
        end
    end

    // Only arithmetic that did not overflow commits and advances the PC.
    assign wb_ok   = ((kind_q == ST_R_TYPE) || (kind_q == ST_I_TYPE)) && !ovf_q;
    assign rf_we   = (state_q == S_WB) && wb_ok;
    assign pc_next = pc_q + ADDR_WIDTH'(4);

    alu_issue_ctrl_reg_file #(
        .DATA_WIDTH(DATA_WIDTH),
        .NUM_REGS  (NUM_REGS)
    ) u_rf (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_raddr_a(rs1),
        .o_rdata_a(rf_a),
        .i_raddr_b(rs2),
        .o_rdata_b(rf_b),
        .i_we     (rf_we),
        .i_waddr  (rd_q),
        .i_wdata  (res_q)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: state_d = S_EXEC;
            S_EXEC:   state_d = S_WB;
            S_WB:     state_d = wb_ok ? S_FETCH : S_HALT;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        o_status_valid = (state_q == S_WB);
        o_halt         = (state_q == S_HALT);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pc_q        <= '0;
            imem_addr_q <= '0;
            rd_q        <= '0;
            kind_q      <= ST_R_TYPE;
            status_q    <= ST_R_TYPE;
            alu_op_q    <= ALU_ADD;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            res_q       <= '0;
            ovf_q       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: imem_addr_q <= pc_q;
                S_DECODE: begin
                    rd_q   <= i_imem_rdata[11:7];
                    kind_q <= dec_kind;
                    // EOF/INVALID leave the ALU operands untouched so they stay stable.
                    if (dec_kind == ST_R_TYPE || dec_kind == ST_I_TYPE) begin
                        alu_op_q <= dec_op;
                        alu_a_q  <= rf_a;
                        alu_b_q  <= dec_imm ? imm_ext : rf_b;
                    end
                end
                S_EXEC: begin
                    res_q <= i_alu_data;
                    ovf_q <= i_alu_overflow;
                    if ((kind_q == ST_R_TYPE || kind_q == ST_I_TYPE) && i_alu_overflow) begin
                        status_q <= ST_INVALID;
                    end else begin
                        status_q <= kind_q;
                    end
                end
                S_WB: begin
                    if (wb_ok) begin
                        pc_q        <= pc_next;
                        imem_addr_q <= pc_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_imem_addr = imem_addr_q;
    assign o_alu_op    = alu_op_q;
    assign o_alu_a     = alu_a_q;
    assign o_alu_b     = alu_b_q;
    assign o_status    = status_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - directed self-checking bench for alu_issue_ctrl
module tb_alu_issue_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic [31:0] o_imem_addr;
    logic [31:0] imem_rdata;
    logic [2:0]  o_alu_op;
    logic [31:0] o_alu_a, o_alu_b;
    logic [31:0] alu_res;
    logic        alu_ovf;
    logic [1:0]  o_status;
    logic        o_status_valid;
    logic        o_halt;

    logic [31:0] mem [0:63];
    int          nvec = 0;
    int          nerr = 0;
    int          cyc = 0;
    int          t_rel = 0;
    int          last_wb = 0;

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;
    always @(posedge i_clk) imem_rdata <= mem[o_imem_addr[7:2]];

    // Reference ALU: ADD/SUB with signed-overflow detection.
    always_comb begin
        if (o_alu_op == 3'd1) begin
            alu_res = o_alu_a - o_alu_b;
            alu_ovf = (o_alu_a[31] != o_alu_b[31]) && (alu_res[31] != o_alu_a[31]);
        end else begin
            alu_res = o_alu_a + o_alu_b;
            alu_ovf = (o_alu_a[31] == o_alu_b[31]) && (alu_res[31] != o_alu_a[31]);
        end
    end

    alu_issue_ctrl dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .o_imem_addr   (o_imem_addr),
        .i_imem_rdata  (imem_rdata),
        .o_alu_op      (o_alu_op),
        .o_alu_a       (o_alu_a),
        .o_alu_b       (o_alu_b),
        .i_alu_data    (alu_res),
        .i_alu_overflow(alu_ovf),
        .o_status      (o_status),
        .o_status_valid(o_status_valid),
        .o_halt        (o_halt)
    );

    function automatic logic [31:0] enc_addi(int rd, int rs1, int imm);
        logic [31:0] im;
        im = imm;
        return {im[11:0], 5'(rs1), 3'b000, 5'(rd), 7'b0010011};
    endfunction

    function automatic logic [31:0] enc_r(logic [6:0] f7, int rd, int rs1, int rs2);
        return {f7, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'b0110011};
    endfunction

    localparam logic [31:0] EOF_W = 32'h0000_0073;

    task automatic clear_mem();
        for (int i = 0; i < 64; i++) mem[i] = EOF_W;
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        i_rst_n = 1'b0;
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        t_rel   = cyc;
        last_wb = cyc;
    endtask

    task automatic wait_wb(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge i_clk);
            if (o_status_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        nvec++;
        if (!ok) begin
            nerr++;
            $display("FAIL %s: no status_valid pulse within 40 cycles", tag);
        end
    endtask

    task automatic test_reset();
        clear_mem();
        i_rst_n = 1'b0;
        repeat (2) @(negedge i_clk);
        nvec++; if (o_imem_addr !== 32'd0) begin nerr++; $display("FAIL rst_addr: got %h want 0", o_imem_addr); end
        nvec++; if (o_alu_op !== 3'd0) begin nerr++; $display("FAIL rst_op: got %0d want 0", o_alu_op); end
        nvec++; if (o_alu_a !== 32'd0 || o_alu_b !== 32'd0) begin nerr++; $display("FAIL rst_ab: got %h %h want 0 0", o_alu_a, o_alu_b); end
        nvec++; if (o_status !== 2'd0 || o_status_valid !== 1'b0) begin nerr++; $display("FAIL rst_status: got %0d/%b want 0/0", o_status, o_status_valid); end
        nvec++; if (o_halt !== 1'b0) begin nerr++; $display("FAIL rst_halt: got %b want 0", o_halt); end
    endtask

    task automatic test_addi_eof();
        clear_mem();
        mem[0] = 32'h0050_0093;
        mem[1] = enc_r(7'h00, 3, 1, 0);
        mem[2] = EOF_W;
        do_reset();
        wait_wb("addi_eof_wb1");
        nvec++; if (cyc - t_rel !== 4) begin nerr++; $display("FAIL first_wb_latency: got %0d want 4", cyc - t_rel); end
        nvec++; if (o_status !== 2'd1) begin nerr++; $display("FAIL addi_status: got %0d want 1", o_status); end
        nvec++; if (o_alu_a !== 32'd0 || o_alu_b !== 32'd5 || o_alu_op !== 3'd0) begin nerr++; $display("FAIL addi_ops: got %h %h %0d want 0 5 0", o_alu_a, o_alu_b, o_alu_op); end
        last_wb = cyc;
        wait_wb("addi_eof_wb2");
        nvec++; if (cyc - last_wb !== 4) begin nerr++; $display("FAIL throughput: got %0d want 4", cyc - last_wb); end
        nvec++; if (o_status !== 2'd0 || o_alu_a !== 32'd5) begin nerr++; $display("FAIL add_x1: got st %0d a %h want 0 5", o_status, o_alu_a); end
        wait_wb("addi_eof_wb3");
        nvec++; if (o_status !== 2'd2) begin nerr++; $display("FAIL eof_status: got %0d want 2", o_status); end
        @(negedge i_clk);
        nvec++; if (o_halt !== 1'b1 || o_status_valid !== 1'b0) begin nerr++; $display("FAIL eof_halt: got halt %b valid %b want 1 0", o_halt, o_status_valid); end
        repeat (5) @(negedge i_clk);
        nvec++; if (o_imem_addr !== 32'd8 || o_halt !== 1'b1 || o_status_valid !== 1'b0) begin nerr++; $display("FAIL eof_hold: got addr %h halt %b valid %b want 8 1 0", o_imem_addr, o_halt, o_status_valid); end
    endtask

    task automatic test_add_sub();
        clear_mem();
        mem[0] = enc_addi(1, 0, 7);
        mem[1] = enc_addi(2, 0, 3);
        mem[2] = 32'h0020_81B3;
        mem[3] = 32'h4020_81B3;
        mem[4] = enc_r(7'h00, 4, 3, 0);
        do_reset();
        repeat (2) wait_wb("addsub_setup");
        wait_wb("add_wb");
        nvec++; if (o_alu_op !== 3'd0 || o_alu_a !== 32'd7 || o_alu_b !== 32'd3 || o_status !== 2'd0) begin nerr++; $display("FAIL add: got op %0d a %h b %h st %0d want 0 7 3 0", o_alu_op, o_alu_a, o_alu_b, o_status); end
        wait_wb("sub_wb");
        nvec++; if (o_alu_op !== 3'd1 || o_alu_a !== 32'd7 || o_alu_b !== 32'd3 || o_status !== 2'd0) begin nerr++; $display("FAIL sub: got op %0d a %h b %h st %0d want 1 7 3 0", o_alu_op, o_alu_a, o_alu_b, o_status); end
        wait_wb("sub_result_wb");
        nvec++; if (o_alu_a !== 32'd4) begin nerr++; $display("FAIL sub_result: got %h want 4", o_alu_a); end
        wait_wb("addsub_eof");
        nvec++; if (o_status !== 2'd2) begin nerr++; $display("FAIL addsub_eof: got %0d want 2", o_status); end
    endtask

    task automatic test_overflow();
        clear_mem();
        mem[0] = enc_addi(1, 0, 1024);
        for (int i = 1; i <= 20; i++) mem[i] = enc_r(7'h00, 1, 1, 1);
        mem[21] = enc_addi(2, 1, -1);
        mem[22] = enc_r(7'h00, 1, 1, 2);
        mem[23] = enc_addi(2, 0, 1);
        mem[24] = enc_addi(3, 0, 9);
        mem[25] = enc_r(7'h00, 3, 1, 2);
        do_reset();
        repeat (25) wait_wb("ovf_setup");
        wait_wb("ovf_wb");
        nvec++; if (o_alu_a !== 32'h7FFF_FFFF || o_alu_b !== 32'd1) begin nerr++; $display("FAIL ovf_ops: got %h %h want 7fffffff 1", o_alu_a, o_alu_b); end
        nvec++; if (o_status !== 2'd3) begin nerr++; $display("FAIL ovf_status: got %0d want 3", o_status); end
        @(negedge i_clk);
        nvec++; if (o_halt !== 1'b1 || o_imem_addr !== 32'd100) begin nerr++; $display("FAIL ovf_halt: got halt %b addr %h want 1 64", o_halt, o_imem_addr); end
        nvec++; if (dut.u_rf.regs_q[3] !== 32'd9) begin nerr++; $display("FAIL ovf_x3: got %h want 9", dut.u_rf.regs_q[3]); end
    endtask

    task automatic test_x0_and_imm();
        clear_mem();
        mem[0] = enc_addi(0, 0, 9);
        mem[1] = enc_r(7'h00, 4, 0, 0);
        mem[2] = 32'hFFF0_0293;
        do_reset();
        wait_wb("x0_write");
        wait_wb("x0_read");
        nvec++; if (o_alu_a !== 32'd0 || o_alu_b !== 32'd0) begin nerr++; $display("FAIL x0_dropped: got %h %h want 0 0", o_alu_a, o_alu_b); end
        wait_wb("imm_sext");
        nvec++; if (o_alu_b !== 32'hFFFF_FFFF || o_status !== 2'd1) begin nerr++; $display("FAIL imm_sext: got b %h st %0d want ffffffff 1", o_alu_b, o_status); end
    endtask

    task automatic test_invalid();
        clear_mem();
        mem[0] = enc_addi(1, 0, 1);
        mem[1] = 32'h0000_007F;
        do_reset();
        wait_wb("inv_setup");
        wait_wb("inv_wb");
        nvec++; if (o_status !== 2'd3) begin nerr++; $display("FAIL inv_status: got %0d want 3", o_status); end
        nvec++; if (o_alu_a !== 32'd0 || o_alu_b !== 32'd1) begin nerr++; $display("FAIL inv_ops_stable: got %h %h want 0 1", o_alu_a, o_alu_b); end
        repeat (6) @(negedge i_clk);
        nvec++; if (o_halt !== 1'b1 || o_status_valid !== 1'b0 || o_imem_addr !== 32'd4) begin nerr++; $display("FAIL inv_halt: got halt %b valid %b addr %h want 1 0 4", o_halt, o_status_valid, o_imem_addr); end
    endtask

    task automatic test_reset_mid_exec();
        clear_mem();
        mem[0] = enc_addi(5, 0, 5);
        do_reset();
        repeat (3) @(negedge i_clk);
        nvec++; if (o_alu_b !== 32'd5) begin nerr++; $display("FAIL midrst_pre: got b %h want 5", o_alu_b); end
        i_rst_n = 1'b0;
        #1;
        nvec++; if (o_alu_b !== 32'd0 || o_status_valid !== 1'b0 || o_imem_addr !== 32'd0 || o_halt !== 1'b0) begin nerr++; $display("FAIL midrst_async: got b %h valid %b addr %h halt %b want 0 0 0 0", o_alu_b, o_status_valid, o_imem_addr, o_halt); end
        mem[0] = enc_r(7'h00, 6, 5, 0);
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        t_rel   = cyc;
        wait_wb("midrst_restart");
        nvec++; if (cyc - t_rel !== 4 || o_status !== 2'd0) begin nerr++; $display("FAIL midrst_restart: got lat %0d st %0d want 4 0", cyc - t_rel, o_status); end
        nvec++; if (o_alu_a !== 32'd0) begin nerr++; $display("FAIL midrst_x5: got %h want 0", o_alu_a); end
    endtask

    initial begin
        test_reset();
        test_addi_eof();
        test_add_sub();
        test_overflow();
        test_x0_and_imm();
        test_invalid();
        test_reset_mid_exec();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
